// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: state encodings,
// alignment mask and the instruction classification used at accept.
package mem_access_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_REQ  = 1'b1
  } mem_state_e;

  // What an accepted instruction turns into in this stage.
  typedef enum logic [1:0] {
    I_PASS  = 2'd0,   // no memory access, forward ALU result
    I_LOAD  = 2'd1,   // aligned LW
    I_STORE = 2'd2,   // aligned SW
    I_BAD   = 2'd3    // misaligned, or both load and store asserted
  } mem_op_e;

  function automatic logic is_word_aligned(input logic [DATA_W-1:0] addr);
    return (addr[1:0] & WORD_ALIGN_MASK) == 2'b00;
  endfunction

  function automatic mem_op_e classify_op(input logic              load,
                                          input logic              store,
                                          input logic [DATA_W-1:0] addr);
    mem_op_e op;
    if (!load && !store)              op = I_PASS;
    else if (load && store)           op = I_BAD;
    else if (!is_word_aligned(addr))  op = I_BAD;
    else if (load)                    op = I_LOAD;
    else                              op = I_STORE;
    return op;
  endfunction

endpackage

// File: rtl/mem_access.sv
// Memory-access stage. Accepts one instruction from EXE while idle, runs a
// req/ack transaction for aligned LW/SW, aborts after TIMEOUT unacked
// request cycles, and issues a one-cycle writeback slot for every accepted
// instruction (pass-through, load data, store completion or error).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   MEM_IDLE | no bus activity; accepts in_valid, stall low
//   MEM_REQ  | mem_req held with captured addr/wdata/we; waits for ack
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              write_reg,
  input  logic              load_en,
  input  logic              store_en,
  input  logic [DATA_W-1:0] res,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_W-1:0]  rd,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic              wb_en,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  mem_state_e        state;
  mem_state_e        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [REG_W-1:0]  rd_q;
  mem_op_e           op;
  logic              accept;
  logic              req_ack;
  logic              req_tout;

  // Classify the incoming instruction and decode transaction endings.
  always_comb begin
    op       = classify_op(load_en, store_en, res);
    accept   = (state == MEM_IDLE) && in_valid;
    cnt_inc  = cnt + CNT_W'(1);
    req_ack  = (state == MEM_REQ) && mem_ack;
    // An ack in the final allowed cycle takes priority over the abort.
    req_tout = (state == MEM_REQ) && !mem_ack && (cnt_inc == CNT_LIMIT);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= MEM_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      MEM_IDLE: if (accept && (op == I_LOAD || op == I_STORE)) state_nxt = MEM_REQ;
      MEM_REQ:  if (req_ack || req_tout)                        state_nxt = MEM_IDLE;
      default:  state_nxt = MEM_IDLE;
    endcase
  end

  // Count unacked request cycles; restarts at zero for every transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == MEM_REQ && state_nxt == MEM_REQ) begin
      cnt <= cnt_inc;
    end else begin
      cnt <= '0;
    end
  end

  // Capture the accepted instruction so the bus sees stable values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rd_q    <= '0;
    end else if (accept) begin
      addr_q  <= res;
      wdata_q <= store_data;
      we_q    <= store_en;
      rd_q    <= rd;
    end
  end

  // Writeback and error pulses, registered so they appear one edge after
  // the deciding event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_en    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      err      <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_en    <= 1'b0;
      err      <= 1'b0;
      if (accept && op == I_PASS) begin
        wb_valid <= 1'b1;
        wb_en    <= write_reg && (rd != '0);
        wb_rd    <= rd;
        wb_data  <= res;
      end else if (accept && op == I_BAD) begin
        wb_valid <= 1'b1;
        err      <= 1'b1;
        wb_rd    <= rd;
        wb_data  <= '0;
      end else if (req_ack) begin
        wb_valid <= 1'b1;
        wb_en    <= !we_q && (rd_q != '0);
        wb_rd    <= rd_q;
        wb_data  <= we_q ? '0 : mem_rdata;
      end else if (req_tout) begin
        wb_valid <= 1'b1;
        err      <= 1'b1;
        wb_rd    <= rd_q;
        wb_data  <= '0;
      end
    end
  end

  // Bus and stall outputs follow the state; bus fields are zero when idle.
  always_comb begin
    stall     = (state != MEM_IDLE);
    mem_req   = (state == MEM_REQ);
    mem_we    = mem_req && we_q;
    mem_addr  = mem_req ? addr_q  : '0;
    mem_wdata = mem_req ? wdata_q : '0;
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, loads/stores with varying
// wait states, timeout, misaligned/illegal accesses and reset behaviour.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, write_reg, load_en, store_en;
  logic [31:0] res, store_data;
  logic [4:0]  rd;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        wb_valid, wb_en, err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam int TIMEOUT = 16;

  mem_access #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .write_reg(write_reg),
    .load_en(load_en), .store_en(store_en), .res(res), .store_data(store_data),
    .rd(rd), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .wb_valid(wb_valid), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs/outputs are touched 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; write_reg = 0; load_en = 0; store_en = 0;
    res = 0; store_data = 0; rd = 0; mem_ack = 0; mem_rdata = 0;
  endtask

  // Status vector order: {stall, mem_req, wb_valid, wb_en, err}
  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    step(); step();
    tests_run++;
    if ({stall, mem_req, wb_valid, wb_en, err} !== 5'b00000) begin
      tests_failed++; $display("FAIL reset_status got=%b exp=00000", {stall, mem_req, wb_valid, wb_en, err});
    end
    tests_run++;
    if ({mem_we, mem_addr, mem_wdata, wb_rd, wb_data} !== '0) begin
      tests_failed++; $display("FAIL reset_buses got we=%b addr=%h wdata=%h rd=%0d data=%h exp all 0", mem_we, mem_addr, mem_wdata, wb_rd, wb_data);
    end
    rst_n = 1;
    step();
  endtask

  task automatic test_passthrough();
    in_valid = 1; write_reg = 1; rd = 5; res = 32'h1234;
    step();
    idle_inputs();
    tests_run++;
    if ({stall, mem_req, wb_valid, wb_en, err} !== 5'b00110) begin
      tests_failed++; $display("FAIL pass_status got=%b exp=00110", {stall, mem_req, wb_valid, wb_en, err});
    end
    tests_run++;
    if (wb_rd !== 5'd5 || wb_data !== 32'h1234) begin
      tests_failed++; $display("FAIL pass_data got rd=%0d data=%h exp rd=5 data=00001234", wb_rd, wb_data);
    end
    step();
    tests_run++;
    if (wb_valid !== 1'b0) begin
      tests_failed++; $display("FAIL pass_pulse got wb_valid=%b exp=0", wb_valid);
    end
    // write_reg=0: slot completes without a register write
    in_valid = 1; write_reg = 0; rd = 9; res = 32'h55;
    step();
    idle_inputs();
    tests_run++;
    if ({stall, wb_valid, wb_en, err, wb_rd} !== {4'b0100, 5'd9}) begin
      tests_failed++; $display("FAIL pass_nowrite got st=%b v=%b en=%b err=%b rd=%0d exp 0 1 0 0 9", stall, wb_valid, wb_en, err, wb_rd);
    end
    // rd=0 is never written
    in_valid = 1; write_reg = 1; rd = 0; res = 32'h77;
    step();
    idle_inputs();
    tests_run++;
    if ({wb_valid, wb_en} !== 2'b10) begin
      tests_failed++; $display("FAIL pass_rd0 got v=%b en=%b exp 1 0", wb_valid, wb_en);
    end
  endtask

  task automatic test_lw_zero_wait();
    in_valid = 1; load_en = 1; res = 32'h100; rd = 3;
    step();
    idle_inputs();
    tests_run++;
    if ({stall, mem_req, mem_we, wb_valid, err} !== 5'b11000 || mem_addr !== 32'h100) begin
      tests_failed++; $display("FAIL lw0_req got st=%b req=%b we=%b v=%b err=%b addr=%h exp 1 1 0 0 0 addr=00000100", stall, mem_req, mem_we, wb_valid, err, mem_addr);
    end
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_ack = 0; mem_rdata = 0;
    tests_run++;
    if ({stall, mem_req, wb_valid, wb_en, err} !== 5'b00110) begin
      tests_failed++; $display("FAIL lw0_status got=%b exp=00110", {stall, mem_req, wb_valid, wb_en, err});
    end
    tests_run++;
    if (wb_rd !== 5'd3 || wb_data !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL lw0_data got rd=%0d data=%h exp rd=3 data=deadbeef", wb_rd, wb_data);
    end
    step();
    tests_run++;
    if ({wb_valid, mem_req} !== 2'b00) begin
      tests_failed++; $display("FAIL lw0_after got v=%b req=%b exp 0 0", wb_valid, mem_req);
    end
  endtask

  task automatic test_sw_wait();
    int bad = 0;
    in_valid = 1; store_en = 1; res = 32'h40; store_data = 32'hA5A5A5A5; rd = 6;
    step();
    idle_inputs();
    for (int c = 1; c <= 4; c++) begin
      if ({stall, mem_req, mem_we, wb_valid} !== 4'b1110 || mem_addr !== 32'h40 || mem_wdata !== 32'hA5A5A5A5) bad++;
      mem_ack = (c == 4);
      step();
    end
    mem_ack = 0;
    tests_run++;
    if (bad != 0) begin
      tests_failed++; $display("FAIL sw_hold got %0d unstable REQ cycles exp 0", bad);
    end
    tests_run++;
    if ({stall, mem_req, wb_valid, wb_en, err} !== 5'b00100 || wb_rd !== 5'd6) begin
      tests_failed++; $display("FAIL sw_done got=%b rd=%0d exp=00100 rd=6", {stall, mem_req, wb_valid, wb_en, err}, wb_rd);
    end
    step();
  endtask

  task automatic test_timeout();
    int n = 0;
    in_valid = 1; load_en = 1; res = 32'h200; rd = 4;
    step();
    idle_inputs();
    while (mem_req && n < 40) begin
      n++;
      step();
    end
    tests_run++;
    if (n != TIMEOUT) begin
      tests_failed++; $display("FAIL timeout_len got %0d req cycles exp %0d", n, TIMEOUT);
    end
    tests_run++;
    if ({stall, mem_req, wb_valid, wb_en, err} !== 5'b00101 || wb_rd !== 5'd4) begin
      tests_failed++; $display("FAIL timeout_status got=%b rd=%0d exp=00101 rd=4", {stall, mem_req, wb_valid, wb_en, err}, wb_rd);
    end
    step();
    tests_run++;
    if ({wb_valid, err} !== 2'b00) begin
      tests_failed++; $display("FAIL timeout_pulse got v=%b err=%b exp 0 0", wb_valid, err);
    end
  endtask

  task automatic test_ack_at_timeout();
    in_valid = 1; load_en = 1; res = 32'h300; rd = 8;
    step();
    idle_inputs();
    for (int c = 1; c < TIMEOUT; c++) step();
    tests_run++;
    if (mem_req !== 1'b1) begin
      tests_failed++; $display("FAIL ackedge_req got req=%b exp 1 in last REQ cycle", mem_req);
    end
    mem_ack = 1; mem_rdata = 32'h0BADF00D;
    step();
    mem_ack = 0; mem_rdata = 0;
    tests_run++;
    if ({stall, mem_req, wb_valid, wb_en, err} !== 5'b00110 || wb_data !== 32'h0BADF00D) begin
      tests_failed++; $display("FAIL ackedge_done got=%b data=%h exp=00110 data=0badf00d", {stall, mem_req, wb_valid, wb_en, err}, wb_data);
    end
    step();
  endtask

  task automatic test_misaligned();
    in_valid = 1; load_en = 1; res = 32'h102; rd = 7;
    step();
    idle_inputs();
    tests_run++;
    if ({stall, mem_req, wb_valid, wb_en, err} !== 5'b00101 || wb_rd !== 5'd7) begin
      tests_failed++; $display("FAIL mis_lw got=%b rd=%0d exp=00101 rd=7", {stall, mem_req, wb_valid, wb_en, err}, wb_rd);
    end
    in_valid = 1; store_en = 1; res = 32'h41; rd = 2;
    step();
    idle_inputs();
    tests_run++;
    if ({stall, mem_req, wb_valid, wb_en, err} !== 5'b00101) begin
      tests_failed++; $display("FAIL mis_sw got=%b exp=00101", {stall, mem_req, wb_valid, wb_en, err});
    end
    // aligned but both load and store: illegal
    in_valid = 1; load_en = 1; store_en = 1; res = 32'h80; rd = 1;
    step();
    idle_inputs();
    tests_run++;
    if ({stall, mem_req, wb_valid, wb_en, err} !== 5'b00101) begin
      tests_failed++; $display("FAIL illegal got=%b exp=00101", {stall, mem_req, wb_valid, wb_en, err});
    end
    step();
    tests_run++;
    if ({mem_req, wb_valid, err} !== 3'b000) begin
      tests_failed++; $display("FAIL mis_after got req=%b v=%b err=%b exp 0 0 0", mem_req, wb_valid, err);
    end
  endtask

  task automatic test_ack_idle();
    mem_ack = 1; mem_rdata = 32'h12345678;
    step(); step();
    mem_ack = 0; mem_rdata = 0;
    tests_run++;
    if ({stall, mem_req, wb_valid, err} !== 4'b0000) begin
      tests_failed++; $display("FAIL ack_idle got st=%b req=%b v=%b err=%b exp 0 0 0 0", stall, mem_req, wb_valid, err);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    in_valid = 1; load_en = 1; res = 32'h500; rd = 0;
    step();
    idle_inputs();
    step();
    rst_n = 0;
    step();
    tests_run++;
    if ({stall, mem_req, wb_valid, err} !== 4'b0000) begin
      tests_failed++; $display("FAIL rst_mid got st=%b req=%b v=%b err=%b exp 0 0 0 0", stall, mem_req, wb_valid, err);
    end
    rst_n = 1;
    mem_ack = 1; mem_rdata = 32'hFFFF0000;
    for (int c = 0; c < 3; c++) begin
      step();
      if (wb_valid || err || mem_req) seen++;
    end
    mem_ack = 0; mem_rdata = 0;
    tests_run++;
    if (seen != 0) begin
      tests_failed++; $display("FAIL rst_late_ack got %0d active cycles exp 0", seen);
    end
    // LW to rd=0 completes without a register write
    in_valid = 1; load_en = 1; res = 32'h504; rd = 0;
    step();
    idle_inputs();
    mem_ack = 1; mem_rdata = 32'hCAFEBABE;
    step();
    mem_ack = 0; mem_rdata = 0;
    tests_run++;
    if ({stall, mem_req, wb_valid, wb_en, err} !== 5'b00100 || wb_rd !== 5'd0) begin
      tests_failed++; $display("FAIL lw_rd0 got=%b rd=%0d exp=00100 rd=0", {stall, mem_req, wb_valid, wb_en, err}, wb_rd);
    end
    step();
  endtask

  // Stall holds EXE inputs: an instruction presented during REQ is taken
  // only after the load completes.
  task automatic test_back_to_back();
    in_valid = 1; load_en = 1; res = 32'h600; rd = 10;
    step();
    load_en = 0; write_reg = 1; rd = 11; res = 32'h99;
    step();
    tests_run++;
    if ({stall, mem_req, wb_valid} !== 3'b110) begin
      tests_failed++; $display("FAIL b2b_stall got st=%b req=%b v=%b exp 1 1 0", stall, mem_req, wb_valid);
    end
    mem_ack = 1; mem_rdata = 32'h600D;
    step();
    mem_ack = 0; mem_rdata = 0;
    tests_run++;
    if ({wb_valid, wb_en, wb_rd, wb_data} !== {2'b11, 5'd10, 32'h600D}) begin
      tests_failed++; $display("FAIL b2b_load got v=%b en=%b rd=%0d data=%h exp 1 1 10 0000600d", wb_valid, wb_en, wb_rd, wb_data);
    end
    step();
    idle_inputs();
    tests_run++;
    if ({wb_valid, wb_en, wb_rd, wb_data} !== {2'b11, 5'd11, 32'h99}) begin
      tests_failed++; $display("FAIL b2b_pass got v=%b en=%b rd=%0d data=%h exp 1 1 11 00000099", wb_valid, wb_en, wb_rd, wb_data);
    end
    step();
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_passthrough();
    test_lw_zero_wait();
    test_sw_wait();
    test_timeout();
    test_ack_at_timeout();
    test_misaligned();
    test_ack_idle();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
